// File: rtl/mux_n_reg.sv
// N-channel registered multiplexer with per-channel valid/ready handshakes.
// The grant comes from an explicit select (mode 0) or a round-robin search (mode 1).
// A single output register gives one cycle of latency and full throughput under backpressure.
module mux_n_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  // Every SELW-bit index has a slot, so indexing stays in range even when sel >= N.
  localparam int unsigned NSLOT = 2 ** SELW;
  localparam int unsigned EXT_W = NSLOT * WIDTH;

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_chan;
  logic             r_valid;
  logic [SELW-1:0]  r_ptr;

  logic [EXT_W-1:0] w_data_ext;
  logic [NSLOT-1:0] w_valid_ext;
  logic [NSLOT-1:0] w_ready_ext;
  logic             w_slot_free;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_gnt;
  logic [SELW-1:0]  w_idx;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptr_nxt;

  assign w_data_ext  = EXT_W'(in_data);
  assign w_valid_ext = NSLOT'(in_valid);
  assign w_slot_free = !r_valid || out_ready;

  // Round-robin search: first valid channel starting at the pointer, wrapping mod N.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_gnt = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = SELW'((32'(r_ptr) + k) % N);
      if (!w_rr_vld && w_valid_ext[w_idx]) begin
        w_rr_vld = 1'b1;
        w_rr_gnt = w_idx;
      end
    end
  end

  // Grant selection, per-channel ready and the transfer condition.
  always_comb begin
    w_ready_ext = '0;
    if (mode) begin
      w_gnt_vld = w_rr_vld;
      w_gnt     = w_rr_gnt;
    end else begin
      w_gnt_vld = (32'(sel) < N);
      w_gnt     = sel;
    end
    if (w_gnt_vld) w_ready_ext[w_gnt] = w_slot_free;
    w_xfer    = w_gnt_vld && w_valid_ext[w_gnt] && w_slot_free;
    w_ptr_nxt = SELW'((32'(w_gnt) + 1) % N);
  end

  assign in_ready = w_ready_ext[N-1:0];

  // Output register and round-robin pointer; a load takes priority over a bare pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      if (w_xfer) begin
        r_data  <= w_data_ext[w_gnt*WIDTH +: WIDTH];
        r_chan  <= w_gnt;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_xfer && mode) r_ptr <= w_ptr_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: three instances cover the 4-channel default,
// a 3-channel out-of-range select case and an 8-bit 2-channel streaming case.
module tb_mux_n_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Instance A: WIDTH=32, N=4, SELW=2
  logic [127:0] a_in_data  = '0;
  logic [3:0]   a_in_valid = '0;
  logic [3:0]   a_in_ready;
  logic         a_mode = 1'b0;
  logic [1:0]   a_sel  = '0;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_chan;
  logic         a_out_valid;
  logic         a_out_ready = 1'b0;

  mux_n_reg #(.WIDTH(32), .N(4), .SELW(2)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mode(a_mode), .sel(a_sel), .out_data(a_out_data), .out_chan(a_out_chan),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  // Instance B: WIDTH=32, N=3, SELW=2, held at sel=3 for the whole run
  logic [95:0] b_in_data  = {32'h3, 32'h2, 32'h1};
  logic [2:0]  b_in_valid = 3'b111;
  logic [2:0]  b_in_ready;
  logic [31:0] b_out_data;
  logic [1:0]  b_out_chan;
  logic        b_out_valid;
  logic        b_rose = 1'b0;

  mux_n_reg #(.WIDTH(32), .N(3), .SELW(2)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode(1'b0), .sel(2'd3), .out_data(b_out_data), .out_chan(b_out_chan),
    .out_valid(b_out_valid), .out_ready(1'b0)
  );

  always @(negedge clk) if (b_out_valid) b_rose = 1'b1;

  // Instance C: WIDTH=8, N=2, SELW=1
  logic [15:0] c_in_data  = 16'hEE00;
  logic [1:0]  c_in_valid = 2'b00;
  logic [1:0]  c_in_ready;
  logic [7:0]  c_out_data;
  logic [0:0]  c_out_chan;
  logic        c_out_valid;
  logic        c_out_ready = 1'b0;

  mux_n_reg #(.WIDTH(8), .N(2), .SELW(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .mode(1'b0), .sel(1'b0), .out_data(c_out_data), .out_chan(c_out_chan),
    .out_valid(c_out_valid), .out_ready(c_out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_chan;
    #12;
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_data", 64'(a_out_data), 64'd0);
    rst = 1'b0;
    #10;

    // Explicit select with backpressure
    a_mode = 1'b0;
    a_sel  = 2'd1;
    a_in_data[32 +: 32] = 32'hA5A5_0001;
    a_in_valid = 4'b0010;
    a_out_ready = 1'b0;
    #1;
    chk("sel_ready_idle", 64'(a_in_ready), 64'b0010);
    step();
    chk("sel_valid", 64'(a_out_valid), 64'd1);
    chk("sel_data", 64'(a_out_data), 64'hA5A5_0001);
    chk("sel_chan", 64'(a_out_chan), 64'd1);
    a_in_data[32 +: 32] = 32'hA5A5_0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 64'(a_in_ready), 64'd0);
      step();
      chk("stall_data", 64'(a_out_data), 64'hA5A5_0001);
      chk("stall_valid", 64'(a_out_valid), 64'd1);
    end
    a_out_ready = 1'b1;
    #1;
    chk("pop_ready", 64'(a_in_ready), 64'b0010);
    step();
    chk("pop_load_data", 64'(a_out_data), 64'hA5A5_0002);
    chk("pop_load_valid", 64'(a_out_valid), 64'd1);
    a_in_valid = 4'b0000;
    step();
    chk("pop_only_valid", 64'(a_out_valid), 64'd0);
    chk("pop_only_hold", 64'(a_out_data), 64'hA5A5_0002);

    // Round-robin fairness, pointer starts at 0
    a_mode = 1'b1;
    a_in_data = {32'd13, 32'd12, 32'd11, 32'd10};
    a_in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_chan = i % 4;
      step();
      chk("rr_chan", 64'(a_out_chan), 64'(exp_chan));
      chk("rr_data", 64'(a_out_data), 64'(10 + exp_chan));
      chk("rr_valid", 64'(a_out_valid), 64'd1);
    end

    // Round-robin skip: pointer is now 2, only ch0 and ch3 valid
    a_in_valid = 4'b1001;
    #1;
    chk("skip_ready3", 64'(a_in_ready), 64'b1000);
    step();
    chk("skip_chan3", 64'(a_out_chan), 64'd3);
    chk("skip_data3", 64'(a_out_data), 64'd13);
    chk("skip_ready0", 64'(a_in_ready), 64'b0001);
    step();
    chk("skip_chan0", 64'(a_out_chan), 64'd0);
    chk("skip_ready_p1", 64'(a_in_ready), 64'b1000);

    // Mode switch is seen combinationally
    a_mode = 1'b0;
    a_sel  = 2'd2;
    #1;
    chk("mode_sw_ready", 64'(a_in_ready), 64'b0100);
    a_mode = 1'b1;
    step();
    chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
    chk("pre_rst_chan", 64'(a_out_chan), 64'd3);

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(a_out_valid), 64'd0);
    chk("arst_data", 64'(a_out_data), 64'd0);
    chk("arst_chan", 64'(a_out_chan), 64'd0);
    a_mode = 1'b0;
    a_sel  = 2'd2;
    a_out_ready = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(a_in_ready), 64'b0100);
    a_mode = 1'b1;
    a_in_valid = 4'b1111;
    #1;
    chk("post_rst_ptr", 64'(a_in_ready), 64'b0001);
    step();
    chk("post_rst_xfer", 64'(a_out_valid), 64'd1);
    chk("post_rst_chan", 64'(a_out_chan), 64'd0);
    chk("post_rst_data", 64'(a_out_data), 64'd10);

    // Out-of-range select on the 3-channel instance
    chk("oor_ready", 64'(b_in_ready), 64'd0);
    chk("oor_valid", 64'(b_out_valid), 64'd0);

    // Full-throughput streaming on the 8-bit instance; ch1 valid but unselected
    c_out_ready = 1'b1;
    c_in_valid  = 2'b11;
    for (int v = 0; v < 256; v++) begin
      c_in_data[7:0] = 8'(v);
      step();
      chk("stream_data", 64'(c_out_data), 64'(v));
      chk("stream_valid", 64'(c_out_valid), 64'd1);
    end
    chk("stream_chan", 64'(c_out_chan), 64'd0);
    c_out_ready = 1'b0;
    c_in_data[7:0] = 8'h55;
    #1;
    chk("stall1_ready", 64'(c_in_ready), 64'd0);
    step();
    chk("stall1_data", 64'(c_out_data), 64'hFF);
    chk("stall1_valid", 64'(c_out_valid), 64'd1);
    c_out_ready = 1'b1;
    step();
    chk("resume_data", 64'(c_out_data), 64'h55);
    chk("oor_never_rose", 64'(b_rose), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
# mux_n_reg

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It is the next-generation datapath selector beside the combinational 2:1 muxes: any channel count, any width, one pipeline register, backpressure, and two selection modes (explicit select or round-robin arbitration). It sits between multiple datapath sources (ALU, register file, immediate, memory) and a single consumer that may stall.

## Interface
Parameters:
- WIDTH, 32, data width of each channel and of the output.
- N, 4, number of input channels; N ≥ 2.
- SELW, 2, width of sel and out_chan; 2^SELW ≥ N is required.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready (combinational).
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SELW  channel index used when mode = 0.
- out_data  out  WIDTH  registered selected data.
- out_chan  out  SELW  index of the channel that supplied out_data.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accepts out_data.

## Operation
- slot_free = !out_valid | out_ready. Output pop occurs when out_valid & out_ready.
- Grant g:
  - mode 0: g = sel. If sel ≥ N, there is no grant.
  - mode 1: g is the first i with in_valid[i] = 1, searching ptr, ptr+1, …, N-1, 0, … (mod N). If no in_valid bit is set, there is no grant.
- in_ready[g] = slot_free. Every other in_ready bit is 0. With no grant, in_ready is all 0.
- Mode 0 ignores in_valid of non-selected channels. Those channels stall indefinitely and are not dropped.
- Transfer occurs when in_valid[g] & in_ready[g]. On a transfer:
  - out_data ← channel g data.
  - out_chan ← g.
  - out_valid ← 1.
- Pop without transfer sets out_valid ← 0. out_data and out_chan hold their last values.
- Simultaneous pop and transfer: the register reloads with the new data and out_valid stays 1. This gives full throughput.
- Round-robin pointer ptr (SELW bits):
  - On a mode-1 transfer, ptr ← (g+1 mod N), so g = N-1 wraps to 0.
  - Mode-0 transfers leave ptr unchanged.
- Mode or sel changes take effect combinationally in the same cycle. A transfer already registered is unaffected.
- Reset (async, any time, including mid-transfer): out_valid = 0, out_data = 0, out_chan = 0, ptr = 0. in_ready follows combinationally from slot_free = 1. Data held at reset is discarded.

## Timing
- Latency is 1 cycle: a transfer at edge k makes out_valid = 1 with the data visible after edge k.
- Throughput is 1 word/cycle while out_ready = 1 and a granted channel stays valid.
- in_ready depends combinationally on out_valid, out_ready, mode, sel, in_valid and ptr. There is no combinational path from in_data to any output.
- Output stability: while out_valid = 1 and out_ready = 0, out_data and out_chan must not change.
- Input contract: a source holds in_data and in_valid until it sees in_ready. The block does not rely on this for correctness.
- Reset release: the first transfer is possible at the first rising edge after rst falls.

## Test plan
- Reset/idle: assert rst mid-stream with out_valid = 1 → out_valid, out_data, out_chan and ptr are 0 immediately, without waiting for a clock. After release, in_ready[sel] = 1 with mode = 0, sel = 2, N = 4.
- Explicit select with backpressure: mode = 0, sel = 1, ch1 = 32'hA5A5_0001 valid, out_ready = 0.
  - Cycle 1: out_valid = 1, out_data = A5A50001, out_chan = 1.
  - Cycles 2–4: in_ready[1] = 0 and out_data holds.
  - Raise out_ready: the pop and the next load happen in the same cycle.
- Out-of-range select: N = 3, SELW = 2, sel = 3, all in_valid = 1 → in_ready = 0 and out_valid never rises.
- Round-robin fairness: mode = 1, N = 4, all channels valid with data 10, 11, 12, 13, out_ready = 1 → out_chan sequence is 0, 1, 2, 3, 0, … at one per cycle, and ptr wraps 3 → 0.
- Round-robin skip: mode = 1, ptr = 2, only ch0 and ch3 valid → grant ch3, ptr ← 0. Next grant is ch0, ptr ← 1.
- Full-throughput streaming: WIDTH = 8, N = 2, mode = 0, sel = 0, ch0 increments 0..255 each cycle with out_ready = 1 → 256 consecutive outputs with no gap and no duplicate. Then drop out_ready for 1 cycle → exactly one stall cycle and no loss.
